// File: rtl/sram_arbiter.sv
// Two-port (CPU / DMA) arbiter for an asynchronous byte-wide SRAM.
// Fixed-length IDLE/SETUP/ACCESS/HOLD cycle, CPU priority with a DMA starvation guard.
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic [7:0]  dma_rdata,
   output logic        dma_ack,
   output logic [15:0] ad,
   output logic [7:0]  dio_out,
   output logic        dio_oe,
   input  logic [7:0]  dio_in,
   output logic        ce_n,
   output logic        oe_n,
   output logic        we_n,
   output logic        busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
   logic [CNT_W-1:0]   starve_cnt, starve_cnt_next;
   logic               owner, owner_next;     // 1 = DMA owns the bus
   logic               lat_we, lat_we_next;
   logic               grant_dma;
   logic               active;

   logic [15:0]        ad_next;
   logic [7:0]         dio_out_next;
   logic [7:0]         cpu_rdata_next, dma_rdata_next;
   logic               dio_oe_next, ce_n_next, oe_n_next, we_n_next;
   logic               cpu_ack_next, dma_ack_next, busy_next;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, grant and next-output logic; outputs are registered below
   always_comb begin
      state_next      = state;
      wait_cnt_next   = wait_cnt;
      starve_cnt_next = starve_cnt;
      owner_next      = owner;
      lat_we_next     = lat_we;
      ad_next         = ad;
      dio_out_next    = dio_out;
      cpu_rdata_next  = cpu_rdata;
      dma_rdata_next  = dma_rdata;
      grant_dma       = 1'b0;

      case (state)
         IDLE: begin
            if (cpu_req || dma_req) begin
               grant_dma    = dma_req && (!cpu_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));
               state_next   = SETUP;
               owner_next   = grant_dma;
               lat_we_next  = grant_dma ? dma_we    : cpu_we;
               ad_next      = grant_dma ? dma_addr  : cpu_addr;
               dio_out_next = grant_dma ? dma_wdata : cpu_wdata;
               if (grant_dma || !dma_req) begin
                  starve_cnt_next = '0;
               end else begin
                  starve_cnt_next = starve_cnt + CNT_W'(1);
               end
            end
         end
         SETUP: begin
            state_next    = ACCESS;
            wait_cnt_next = CNT_W'(WAIT_CYCLES - 1);
         end
         ACCESS: begin
            if (wait_cnt == '0) begin
               state_next = HOLD;
               // Read data is captured on the edge that ends the last ACCESS cycle
               if (!lat_we) begin
                  if (owner) begin
                     dma_rdata_next = dio_in;
                  end else begin
                     cpu_rdata_next = dio_in;
                  end
               end
            end else begin
               wait_cnt_next = wait_cnt - CNT_W'(1);
            end
         end
         HOLD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      active       = (state_next != IDLE);
      ce_n_next    = !active;
      oe_n_next    = !(active && !lat_we_next);
      we_n_next    = !((state_next == ACCESS) && lat_we_next);
      dio_oe_next  = active && lat_we_next;
      cpu_ack_next = (state_next == HOLD) && !owner_next;
      dma_ack_next = (state_next == HOLD) && owner_next;
      busy_next    = active;
   end

   // Registered datapath and SRAM/handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt   <= '0;
         starve_cnt <= '0;
         owner      <= 1'b0;
         lat_we     <= 1'b0;
         ad         <= '0;
         dio_out    <= '0;
         dio_oe     <= 1'b0;
         ce_n       <= 1'b1;
         oe_n       <= 1'b1;
         we_n       <= 1'b1;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
         cpu_ack    <= 1'b0;
         dma_ack    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wait_cnt   <= wait_cnt_next;
         starve_cnt <= starve_cnt_next;
         owner      <= owner_next;
         lat_we     <= lat_we_next;
         ad         <= ad_next;
         dio_out    <= dio_out_next;
         dio_oe     <= dio_oe_next;
         ce_n       <= ce_n_next;
         oe_n       <= oe_n_next;
         we_n       <= we_n_next;
         cpu_rdata  <= cpu_rdata_next;
         dma_rdata  <= dma_rdata_next;
         cpu_ack    <= cpu_ack_next;
         dma_ack    <= dma_ack_next;
         busy       <= busy_next;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle strobe checks plus a scoreboard of
// expected owner/read data popped on every ack.
module tb_sram_arbiter;

   localparam int unsigned W  = 2;
   localparam int unsigned SL = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [15:0] cpu_addr, dma_addr;
   logic [7:0]  cpu_wdata, dma_wdata, dio_in;
   logic [7:0]  cpu_rdata, dma_rdata, dio_out;
   logic        cpu_ack, dma_ack, dio_oe, ce_n, oe_n, we_n, busy;
   logic [15:0] ad;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] cpu_rd_m, dma_rd_m;
   bit         sb_owner[$];
   logic [7:0] sb_rdata[$];
   bit         ord_q[$];

   sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .ad(ad), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in),
      .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      repeat (2) tick();
      reset    = 1'b0;
      cpu_rd_m = 8'h00;
      dma_rd_m = 8'h00;
   endtask

   task automatic check_idle(input string tag, input logic [15:0] exp_ad);
      chk({tag, "_ce_n"}, ce_n, 1);
      chk({tag, "_oe_n"}, oe_n, 1);
      chk({tag, "_we_n"}, we_n, 1);
      chk({tag, "_dio_oe"}, dio_oe, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ad"}, ad, exp_ad);
      chk({tag, "_acks"}, {cpu_ack, dma_ack}, 0);
   endtask

   // Pop one scoreboard entry on an ack and compare owner and read data
   task automatic sb_pop();
      bit         e_own;
      logic [7:0] e_rd;
      if (sb_owner.size() == 0) begin
         chk("sb_unexpected_ack", 1, 0);
      end else begin
         e_own = sb_owner.pop_front();
         e_rd  = sb_rdata.pop_front();
         chk("sb_owner", dma_ack, e_own);
         chk("sb_rdata", e_own ? dma_rdata : cpu_rdata, e_rd);
         chk("sb_other_rdata", e_own ? cpu_rdata : dma_rdata, e_own ? cpu_rd_m : dma_rd_m);
      end
   endtask

   // Called in an IDLE cycle; runs one transaction and ends in the following IDLE cycle
   task automatic txn(input bit is_dma, input bit we, input logic [15:0] addr,
                      input logic [7:0] wdata, input logic [7:0] din,
                      input bit churn, input bit keep, input bit pulse_cpu);
      bit hold, acc;
      sb_owner.push_back(is_dma);
      sb_rdata.push_back(we ? (is_dma ? dma_rd_m : cpu_rd_m) : din);
      if (is_dma) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      dio_in = din;
      for (int k = 1; k <= int'(W) + 2; k++) begin
         tick();
         hold = (k == int'(W) + 2);
         acc  = (k >= 2) && (k <= int'(W) + 1);
         chk("ce_n", ce_n, 0);
         chk("oe_n", oe_n, we);
         chk("we_n", we_n, !(acc && we));
         chk("dio_oe", dio_oe, we);
         if (we) chk("dio_out", dio_out, wdata);
         chk("ad", ad, addr);
         chk("busy", busy, 1);
         chk("cpu_ack", cpu_ack, hold && !is_dma);
         chk("dma_ack", dma_ack, hold && is_dma);
         if (cpu_ack || dma_ack) sb_pop();
         if (churn && k == 2) begin
            if (is_dma) begin
               dma_addr = addr ^ 16'h0030; dma_wdata = ~wdata;
            end else begin
               cpu_addr = addr ^ 16'h0030; cpu_wdata = ~wdata;
            end
         end
         if (hold) begin
            if (!keep) begin
               if (is_dma) dma_req = 1'b0;
               else        cpu_req = 1'b0;
            end
            if (pulse_cpu) cpu_req = 1'b1;
         end
      end
      if (!we) begin
         if (is_dma) dma_rd_m = din;
         else        cpu_rd_m = din;
      end
      tick();
      check_idle("idle", addr);
      if (pulse_cpu) cpu_req = 1'b0;
   endtask

   initial begin
      int         n_ack, last, acks;
      bit         e;
      cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_we = 0; dma_addr = '0; dma_wdata = '0;
      dio_in = '0;

      // Reset state
      do_reset();
      check_idle("rst", 16'h0000);
      chk("rst_dio_out", dio_out, 8'h00);
      chk("rst_cpu_rdata", cpu_rdata, 8'h00);
      chk("rst_dma_rdata", dma_rdata, 8'h00);

      // CPU read, DMA write, CPU write with input churn
      txn(0, 0, 16'h1234, 8'h00, 8'hA5, 0, 0, 0);
      chk("cpu_read_rdata", cpu_rdata, 8'hA5);
      txn(1, 1, 16'h7FFF, 8'h3C, 8'h00, 0, 0, 0);
      chk("dma_write_cpu_rdata", cpu_rdata, 8'hA5);
      txn(0, 1, 16'h0010, 8'h11, 8'hEE, 1, 0, 0);

      // CPU pulse during DMA HOLD is dropped; DMA req held past ack restarts DMA
      txn(1, 0, 16'h0100, 8'h00, 8'h6E, 0, 1, 1);
      txn(1, 0, 16'h0200, 8'h00, 8'h77, 0, 0, 0);
      chk("late_dma_rdata", dma_rdata, 8'h77);
      chk("late_cpu_rdata", cpu_rdata, 8'hA5);
      chk("sb_drained", sb_owner.size(), 0);

      // Both requests held high: CPU x4, DMA, CPU x4, DMA
      do_reset();
      for (int r = 0; r < 2; r++) begin
         repeat (SL) ord_q.push_back(1'b0);
         ord_q.push_back(1'b1);
      end
      cpu_we = 0; dma_we = 0; cpu_addr = 16'h0AAA; dma_addr = 16'h0BBB; dio_in = 8'h5A;
      cpu_req = 1; dma_req = 1;
      n_ack = 0; last = 0;
      for (int c = 1; c <= 80 && n_ack < 10; c++) begin
         tick();
         if (cpu_ack && dma_ack) chk("double_ack", 1, 0);
         if (cpu_ack || dma_ack) begin
            e = ord_q.pop_front();
            chk("grant_order", dma_ack, e);
            if (n_ack == 0) chk("first_ack_cycle", c, W + 2);
            else            chk("grant_gap", c - last, W + 3);
            last = c;
            n_ack++;
            if (n_ack == 10) begin
               cpu_req = 0; dma_req = 0;
            end
         end
      end
      chk("grant_count", n_ack, 10);
      tick();
      chk("arb_end_busy", busy, 0);

      // Reset during ACCESS of a write
      do_reset();
      cpu_we = 1; cpu_addr = 16'h0042; cpu_wdata = 8'h99; cpu_req = 1;
      tick();
      tick();
      chk("pre_rst_we_n", we_n, 0);
      #2 reset = 1'b1;
      #1;
      chk("abort_we_n", we_n, 1);
      chk("abort_ce_n", ce_n, 1);
      chk("abort_dio_oe", dio_oe, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ad", ad, 16'h0000);
      cpu_req = 0;
      tick();
      reset = 1'b0;
      acks = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (cpu_ack || dma_ack || busy) acks++;
      end
      chk("abort_no_ack", acks, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
